// File: rtl/netwalk_stats_pkg.sv
// rtl/netwalk_stats_pkg.sv - shared widths, readout FSM encoding and stat entry type
package netwalk_stats_pkg;

  localparam int PKT_CNT_WIDTH  = 32;
  localparam int BYTE_CNT_WIDTH = 48;
  localparam int MISS_CNT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SNAP = 2'd1,
    ACK  = 2'd2
  } rd_state_e;

  typedef struct packed {
    logic [PKT_CNT_WIDTH-1:0]  pkt_cnt;
    logic [BYTE_CNT_WIDTH-1:0] byte_cnt;
  } stat_entry_t;

endpackage

// File: rtl/netwalk_stat_adder.sv
// rtl/netwalk_stat_adder.sv - counter adder, wraps or clamps at all-ones on carry out
module netwalk_stat_adder #(
  parameter int WIDTH = 32,
  parameter bit SAT   = 1'b0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  logic [WIDTH:0] full;

  always_comb begin
    full = {1'b0, a} + {1'b0, b};
    if (SAT && full[WIDTH]) begin
      sum = '1;
    end else begin
      sum = full[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/netwalk_flow_stats.sv
// rtl/netwalk_flow_stats.sv - per-flow packet/byte and table-miss counters with req/ack readout
// Define NETWALK_FLOW_STATS_SAT_EN to make every counter saturate instead of wrapping.
module netwalk_flow_stats
  import netwalk_stats_pkg::*;
#(
  parameter int TCAM_ADDR_WIDTH = 6,
  parameter int PKT_CNT_WIDTH   = netwalk_stats_pkg::PKT_CNT_WIDTH,
  parameter int BYTE_CNT_WIDTH  = netwalk_stats_pkg::BYTE_CNT_WIDTH,
  parameter int PKT_LEN_WIDTH   = 16,
  parameter int MISS_CNT_WIDTH  = netwalk_stats_pkg::MISS_CNT_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       glbl_program_en,
  input  logic                       of_match_found,
  input  logic                       of_table_missed,
  input  logic [TCAM_ADDR_WIDTH-1:0] of_matched_decoded_addr_out,
  input  logic [PKT_LEN_WIDTH-1:0]   pkt_len_in,
  input  logic                       stat_rd_req,
  input  logic [TCAM_ADDR_WIDTH-1:0] stat_rd_addr,
  input  logic                       stat_rd_clear,
  output logic                       stat_rd_ack,
  output logic [PKT_CNT_WIDTH-1:0]   stat_rd_pkt_cnt,
  output logic [BYTE_CNT_WIDTH-1:0]  stat_rd_byte_cnt,
  output logic [MISS_CNT_WIDTH-1:0]  stat_miss_cnt
);

`ifdef NETWALK_FLOW_STATS_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  localparam int ENTRIES = 1 << TCAM_ADDR_WIDTH;

  logic                       ev_valid_q, ev_valid_d;
  logic                       ev_miss_q, ev_miss_d;
  logic [TCAM_ADDR_WIDTH-1:0] ev_addr_q, ev_addr_d;
  logic [PKT_LEN_WIDTH-1:0]   ev_len_q, ev_len_d;

  logic [PKT_CNT_WIDTH-1:0]   pkt_cnt_q  [ENTRIES];
  logic [PKT_CNT_WIDTH-1:0]   pkt_cnt_d  [ENTRIES];
  logic [BYTE_CNT_WIDTH-1:0]  byte_cnt_q [ENTRIES];
  logic [BYTE_CNT_WIDTH-1:0]  byte_cnt_d [ENTRIES];
  logic [MISS_CNT_WIDTH-1:0]  miss_cnt_q, miss_cnt_d;

  rd_state_e                  state_q;
  logic [TCAM_ADDR_WIDTH-1:0] rd_addr_q;
  logic                       rd_clear_q;
  logic                       rd_ack_q;
  logic [PKT_CNT_WIDTH-1:0]   rd_pkt_q;
  logic [BYTE_CNT_WIDTH-1:0]  rd_byte_q;

  logic                       snap_clear;
  logic                       clear_hit;
  logic [PKT_CNT_WIDTH-1:0]   pkt_base, pkt_sum;
  logic [BYTE_CNT_WIDTH-1:0]  byte_base, byte_inc, byte_sum;
  logic [MISS_CNT_WIDTH-1:0]  miss_sum;

  // Stage 1: capture; the address/length hold while programming so ev_* stays quiet.
  always_comb begin
    ev_valid_d = of_match_found & ~glbl_program_en;
    ev_miss_d  = of_table_missed & ~glbl_program_en;
    ev_addr_d  = glbl_program_en ? ev_addr_q : of_matched_decoded_addr_out;
    ev_len_d   = glbl_program_en ? ev_len_q : pkt_len_in;
  end

  // A clear colliding with an update starts the new epoch from zero, so the packet lands once.
  assign snap_clear = (state_q == SNAP) && rd_clear_q;
  assign clear_hit  = snap_clear && (rd_addr_q == ev_addr_q);
  assign pkt_base   = clear_hit ? '0 : pkt_cnt_q[ev_addr_q];
  assign byte_base  = clear_hit ? '0 : byte_cnt_q[ev_addr_q];
  assign byte_inc   = BYTE_CNT_WIDTH'(ev_len_q);

  netwalk_stat_adder #(.WIDTH(PKT_CNT_WIDTH), .SAT(SAT_EN)) u_pkt_add (
    .a   (pkt_base),
    .b   (PKT_CNT_WIDTH'(1)),
    .sum (pkt_sum)
  );

  netwalk_stat_adder #(.WIDTH(BYTE_CNT_WIDTH), .SAT(SAT_EN)) u_byte_add (
    .a   (byte_base),
    .b   (byte_inc),
    .sum (byte_sum)
  );

  netwalk_stat_adder #(.WIDTH(MISS_CNT_WIDTH), .SAT(SAT_EN)) u_miss_add (
    .a   (miss_cnt_q),
    .b   (MISS_CNT_WIDTH'(1)),
    .sum (miss_sum)
  );

  // Stage 2: update runs every cycle regardless of readout state.
  always_comb begin
    pkt_cnt_d  = pkt_cnt_q;
    byte_cnt_d = byte_cnt_q;
    if (snap_clear) begin
      pkt_cnt_d[rd_addr_q]  = '0;
      byte_cnt_d[rd_addr_q] = '0;
    end
    if (ev_valid_q) begin
      pkt_cnt_d[ev_addr_q]  = pkt_sum;
      byte_cnt_d[ev_addr_q] = byte_sum;
    end
    miss_cnt_d = ev_miss_q ? miss_sum : miss_cnt_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ev_valid_q <= 1'b0;
      ev_miss_q  <= 1'b0;
      ev_addr_q  <= '0;
      ev_len_q   <= '0;
      miss_cnt_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        pkt_cnt_q[i]  <= '0;
        byte_cnt_q[i] <= '0;
      end
    end else begin
      ev_valid_q <= ev_valid_d;
      ev_miss_q  <= ev_miss_d;
      ev_addr_q  <= ev_addr_d;
      ev_len_q   <= ev_len_d;
      miss_cnt_q <= miss_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  // Readout: the snapshot takes the pre-update value of the addressed entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      rd_addr_q  <= '0;
      rd_clear_q <= 1'b0;
      rd_ack_q   <= 1'b0;
      rd_pkt_q   <= '0;
      rd_byte_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          rd_ack_q <= 1'b0;
          if (stat_rd_req) begin
            rd_addr_q  <= stat_rd_addr;
            rd_clear_q <= stat_rd_clear;
            state_q    <= SNAP;
          end
        end
        SNAP: begin
          rd_pkt_q  <= pkt_cnt_q[rd_addr_q];
          rd_byte_q <= byte_cnt_q[rd_addr_q];
          rd_ack_q  <= 1'b1;
          state_q   <= ACK;
        end
        ACK: begin
          rd_ack_q <= 1'b0;
          state_q  <= IDLE;
        end
        default: begin
          rd_ack_q <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign stat_rd_ack      = rd_ack_q;
  assign stat_rd_pkt_cnt  = rd_pkt_q;
  assign stat_rd_byte_cnt = rd_byte_q;
  assign stat_miss_cnt    = miss_cnt_q;

endmodule

// File: doc/netwalk_flow_stats.md
Name: netwalk_flow_stats

Overview:
Per-flow statistics stage directly downstream of the TCAM match core. Consumes the per-packet match result and keeps 64 per-entry packet/byte counters plus a table-miss counter. Registered event capture is followed by a counter update one cycle later. A req/ack readout port, with optional clear-on-read, serves the control plane.

Parameters:
TCAM_ADDR_WIDTH, 6, entry index width; entries = 1<<TCAM_ADDR_WIDTH
PKT_CNT_WIDTH, 32, per-entry packet counter width
BYTE_CNT_WIDTH, 48, per-entry byte counter width
PKT_LEN_WIDTH, 16, packet length field width
MISS_CNT_WIDTH, 32, table-miss counter width

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
glbl_program_en  in  1  high: event capture frozen, readout still served
of_match_found  in  1  qualified match strobe from TCAM core
of_table_missed  in  1  qualified miss strobe from TCAM core
of_matched_decoded_addr_out  in  TCAM_ADDR_WIDTH  matched entry index
pkt_len_in  in  PKT_LEN_WIDTH  byte length of current packet
stat_rd_req  in  1  readout request, level, held until ack
stat_rd_addr  in  TCAM_ADDR_WIDTH  entry to read
stat_rd_clear  in  1  clear entry after read, sampled with req
stat_rd_ack  out  1  one-cycle pulse, data valid
stat_rd_pkt_cnt  out  PKT_CNT_WIDTH  packet count snapshot
stat_rd_byte_cnt  out  BYTE_CNT_WIDTH  byte count snapshot
stat_miss_cnt  out  MISS_CNT_WIDTH  running table-miss count

Behaviour:
- Reset (async, reset==0): all counters, capture regs, stat_rd_* outputs and stat_miss_cnt go to 0; FSM to IDLE. Applies mid-readout too; a pending req restarts from IDLE after release.
- Stage 1, capture: at each edge with glbl_program_en==0, register ev_valid=of_match_found, ev_miss=of_table_missed, ev_addr, ev_len. With glbl_program_en==1, ev_valid and ev_miss are forced to 0.
- Stage 2, update: at edge after capture, if ev_valid: pkt_cnt[ev_addr]+=1 and byte_cnt[ev_addr]+=ev_len (zero-extended). If ev_miss: miss_cnt+=1.
- Latency: match at edge N is visible in counters after edge N+1.
- Both strobes high together is illegal upstream. If it happens, both updates are applied.
- Default arithmetic wraps modulo 2^width (see optional feature).
- Readout FSM states: IDLE, SNAP, ACK.
  - IDLE -> SNAP when stat_rd_req==1; latch rd_addr and rd_clear.
  - SNAP: at edge, copy the entry's pre-update value (value before any same-edge stage-2 update) to stat_rd_pkt_cnt/stat_rd_byte_cnt. Go to ACK.
  - If rd_clear: the entry is written 0, plus the same-edge stage-2 increment if ev_addr matches. A colliding packet is therefore counted in the new epoch, never lost, never double-counted.
  - ACK: stat_rd_ack=1 for exactly one cycle; then IDLE. Data outputs hold until the next SNAP.
  - Requester must drop req on ack. Req still high in IDLE starts a new read.
- Throughput: one read per 3 cycles. Stage-2 update runs every cycle regardless of FSM state.

Optional Feature:
NETWALK_FLOW_STATS_SAT_EN
- Defined: all counters saturate at all-ones and stay there until cleared or reset. Byte counter saturates if the sum overflows.
- Undefined: all counters wrap modulo 2^width.

Decomposition:
- Package netwalk_stats_pkg holds the width constants (PKT_CNT_WIDTH, BYTE_CNT_WIDTH, MISS_CNT_WIDTH), FSM state encoding (IDLE=2'd0, SNAP=2'd1, ACK=2'd2), and a stat-entry struct {pkt_cnt, byte_cnt}.
- One sub-module, netwalk_stat_adder: parametric width adder with wrap/saturate select. Instantiated for pkt, byte and miss paths.

Test Plan:
- Reset then 3 matches to addr 5, len 64/128/1500, then read addr 5 no-clear -> ack pulse, pkt_cnt=3, byte_cnt=1692; re-read gives same.
- 4 misses with glbl_program_en=1 then 2 misses with it 0 -> stat_miss_cnt=2.
- Read-clear addr 9 (pkt=7) with a match to addr 9 len 100 in the SNAP cycle -> returned pkt=7, next read pkt=1, byte=100.
- Match stream to addr 2 every cycle while reading addr 3 -> addr 3 unchanged, addr 2 count equals number of matches.
- Preload addr 1 pkt=0xFFFFFFFF, one match -> SAT_EN defined: 0xFFFFFFFF; undefined: 0.
- Assert reset during SNAP -> ack never pulses, all outputs 0; after release a held req completes normally with 0 counts.
